// File: rtl/paraleloserial_pkg.sv
// rtl/paraleloserial_pkg.sv - shared symbols, link states and word-phase constant for the slot scheduler
package paraleloserial_pkg;

    localparam logic [7:0] COMMA_SYM   = 8'hBC;
    localparam logic [7:0] IDLE_SYM    = 8'h7C;
    localparam logic [2:0] WORD_PH_MAX = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } link_state_e;

endpackage

// File: rtl/paraleloserial_sched_rr_arbiter4.sv
// rtl/paraleloserial_sched_rr_arbiter4.sv - 4-way round-robin arbiter, one-hot grant plus index
// With PARALELOSERIAL_PRIO0_EN lane 0 wins outright and the pointer rotates over lanes 1..3 only.
module rr_arbiter4
    import paraleloserial_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id
);

    logic [3:0] rr_req;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        idx    = '0;
        found  = 1'b0;
        rr_req = req;
`ifdef PARALELOSERIAL_PRIO0_EN
        rr_req[0] = 1'b0;
        if (req[0]) begin
            gnt[0] = 1'b1;
            found  = 1'b1;
        end
`endif
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && rr_req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/paraleloserial_sched.sv
// rtl/paraleloserial_sched.sv - word-slot scheduler feeding the parallel-to-serial converter
// Optional strict lane-0 priority is selected with PARALELOSERIAL_PRIO0_EN.
module paraleloserial_sched #(
    parameter int         NREQ       = 4,
    parameter int         SYNC_WORDS = 4,
    parameter logic [7:0] COMMA_SYM  = paraleloserial_pkg::COMMA_SYM,
    parameter logic [7:0] IDLE_SYM   = paraleloserial_pkg::IDLE_SYM
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              link_en,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        ser_data,
    output logic              ser_valid,
    output logic              ser_load,
    output logic [1:0]        grant_id,
    output logic [1:0]        link_state
);

    paraleloserial_pkg::link_state_e state_q, state_d;

    logic [2:0] ph_q, ph_d;
    logic [3:0] sync_cnt_q, sync_cnt_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0] ser_data_q, ser_data_d;
    logic       ser_valid_q, ser_valid_d;
    logic       ser_load_q, ser_load_d;
    logic [1:0] grant_id_q, grant_id_d;

    logic       boundary;
    logic       grant_en;
    logic [3:0] arb_gnt;
    logic [1:0] arb_id;

    assign boundary = (ph_q == paraleloserial_pkg::WORD_PH_MAX);
    assign grant_en = boundary && (state_q == paraleloserial_pkg::ST_ACTIVE) && link_en;

    rr_arbiter4 u_arb (
        .req    (req_valid[3:0]),
        .ptr    (rr_ptr_q),
        .gnt    (arb_gnt),
        .gnt_id (arb_id)
    );

    always_comb begin
        ph_d        = ph_q + 3'd1;
        ser_load_d  = boundary;
        state_d     = state_q;
        sync_cnt_d  = sync_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        ser_data_d  = ser_data_q;
        ser_valid_d = ser_valid_q;
        grant_id_d  = grant_id_q;

        if (boundary) begin
            // The word emitted in a slot reflects the state before the transition.
            ser_data_d  = IDLE_SYM;
            ser_valid_d = 1'b0;
            case (state_q)
                paraleloserial_pkg::ST_IDLE: begin
                    if (link_en) begin
                        state_d    = paraleloserial_pkg::ST_SYNC;
                        sync_cnt_d = '0;
                    end
                end
                paraleloserial_pkg::ST_SYNC: begin
                    if (!link_en) begin
                        state_d = paraleloserial_pkg::ST_IDLE;
                    end else begin
                        ser_data_d = COMMA_SYM;
                        sync_cnt_d = sync_cnt_q + 4'd1;
                        if (sync_cnt_q + 4'd1 == SYNC_WORDS[3:0]) begin
                            state_d = paraleloserial_pkg::ST_ACTIVE;
                        end
                    end
                end
                paraleloserial_pkg::ST_ACTIVE: begin
                    if (!link_en) begin
                        state_d = paraleloserial_pkg::ST_IDLE;
                    end else if (|arb_gnt) begin
                        ser_data_d  = req_data[8*arb_id +: 8];
                        ser_valid_d = 1'b1;
                        grant_id_d  = arb_id;
`ifdef PARALELOSERIAL_PRIO0_EN
                        // Lane 0 grants leave the 1..3 rotation untouched.
                        if (arb_id != 2'd0) begin
                            rr_ptr_d = arb_id + 2'd1;
                        end
`else
                        rr_ptr_d = arb_id + 2'd1;
`endif
                    end
                end
                default: begin
                    state_d = paraleloserial_pkg::ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            ph_q        <= '0;
            state_q     <= paraleloserial_pkg::ST_IDLE;
            sync_cnt_q  <= '0;
            rr_ptr_q    <= '0;
            ser_data_q  <= COMMA_SYM;
            ser_valid_q <= 1'b0;
            ser_load_q  <= 1'b0;
            grant_id_q  <= '0;
        end else begin
            ph_q        <= ph_d;
            state_q     <= state_d;
            sync_cnt_q  <= sync_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            ser_data_q  <= ser_data_d;
            ser_valid_q <= ser_valid_d;
            ser_load_q  <= ser_load_d;
            grant_id_q  <= grant_id_d;
        end
    end

    always_comb begin
        req_ready      = '0;
        req_ready[3:0] = grant_en ? arb_gnt : 4'b0000;
    end

    assign ser_data   = ser_data_q;
    assign ser_valid  = ser_valid_q;
    assign ser_load   = ser_load_q;
    assign grant_id   = grant_id_q;
    assign link_state = state_q;

endmodule
